mbscore_fetch: RTL and testbench

//  Instruction-fetch stage upstream of the core controller. Holds PC and instruction register (IR),

---
 rtl/mbscore_fetch.sv | 142 ++++++++++++++
 tb/tb_mbscore_fetch.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbscore_fetch.sv
// mbscore_fetch: instruction-fetch stage between the core controller and the
// instruction-memory port. It holds PC and IR, issues imem reads on inst_re,
// and picks the next PC (sequential, jump, branch, JR, halt) on next.
module mbscore_fetch #(
  parameter int              ADDR_WIDTH = 32,
  parameter int              DATA_WIDTH = 32,
  parameter logic [31:0]     RESET_PC   = 32'h00000000,
  parameter logic [7:0]      TIMEOUT    = 8'd255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stop,
  input  logic                  inst_re,
  input  logic                  next,
  input  logic                  JAL_or_J,
  input  logic                  BEQ_or_BNE,
  input  logic                  JR,
  input  logic                  hlt,
  input  logic                  alu_flag,
  input  logic [DATA_WIDTH-1:0] rs_data,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  imem_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic                  pause,
  output logic                  halted,
  output logic                  fetch_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] PC_RESET = ADDR_WIDTH'(RESET_PC);

  logic [1:0]            state;
  logic [7:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] jump_target;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic [ADDR_WIDTH-1:0] raw_target;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic [ADDR_WIDTH-1:0] npc_sel;
  logic                  take_next;
  logic                  target_misaligned;
  logic                  halt_now;

  assign pc_plus4      = pc + PC_STEP;
  assign jump_target   = {pc_plus4[ADDR_WIDTH-1:28], inst[25:0], 2'b00};
  assign branch_target = pc_plus4 + {{(ADDR_WIDTH-18){inst[15]}}, inst[15:0], 2'b00};

  // next-PC selection, highest priority first: halt, JR, jump, taken branch, sequential
  always_comb begin
    raw_target = pc_plus4;
    if (hlt) begin
      raw_target = pc;
    end else if (JR) begin
      raw_target = rs_data[ADDR_WIDTH-1:0];
    end else if (JAL_or_J) begin
      raw_target = jump_target;
    end else if (BEQ_or_BNE && alu_flag) begin
      raw_target = branch_target;
    end
  end

  assign target_misaligned = |raw_target[1:0];
  assign next_pc           = {raw_target[ADDR_WIDTH-1:2], 2'b00};
  assign take_next         = next && (state == ST_IDLE);
  assign halt_now          = take_next && hlt;
  assign npc_sel           = take_next ? next_pc : pc;
  assign pause             = (state == ST_WAIT) && !imem_ready;

  // fetch FSM, PC/IR update, request handshake and wait-cycle watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pc        <= PC_RESET;
      inst      <= '0;
      imem_req  <= 1'b0;
      imem_addr <= PC_RESET;
      halted    <= 1'b0;
      fetch_err <= 1'b0;
      wait_cnt  <= 8'd0;
    end else if (stop) begin
      state     <= ST_IDLE;
      pc        <= PC_RESET;
      inst      <= '0;
      imem_req  <= 1'b0;
      imem_addr <= PC_RESET;
      halted    <= 1'b0;
      fetch_err <= 1'b0;
      wait_cnt  <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take_next) begin
            pc <= next_pc;
            if (target_misaligned) begin
              fetch_err <= 1'b1;
            end
            if (hlt) begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end
          end
          if (inst_re && !halt_now) begin
            imem_req  <= 1'b1;
            imem_addr <= npc_sel;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_ready) begin
            inst     <= imem_rdata;
            imem_req <= 1'b0;
            wait_cnt <= 8'd0;
            state    <= ST_IDLE;
          end else if (wait_cnt == TIMEOUT - 8'd1) begin
            fetch_err <= 1'b1;
            inst      <= '0;
            imem_req  <= 1'b0;
            wait_cnt  <= 8'd0;
            state     <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_HALT: begin
          imem_req <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mbscore_fetch.sv
// tb_mbscore_fetch: directed bench for the fetch stage. A transaction-level
// model tracks the architectural PC/IR/request state and is compared against
// the DUT on every falling edge; literal expectations pin the model itself.
module tb_mbscore_fetch;

  logic        clk;
  logic        rst_n;
  logic        stop;
  logic        inst_re;
  logic        next;
  logic        JAL_or_J;
  logic        BEQ_or_BNE;
  logic        JR;
  logic        hlt;
  logic        alu_flag;
  logic [31:0] rs_data;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pause;
  logic        halted;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;
  int pause_cnt = 0;

  mbscore_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stop       (stop),
    .inst_re    (inst_re),
    .next       (next),
    .JAL_or_J   (JAL_or_J),
    .BEQ_or_BNE (BEQ_or_BNE),
    .JR         (JR),
    .hlt        (hlt),
    .alu_flag   (alu_flag),
    .rs_data    (rs_data),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .inst       (inst),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .pause      (pause),
    .halted     (halted),
    .fetch_err  (fetch_err)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_inst, m_addr;
  logic        m_busy, m_halted, m_err;
  int          m_waited;

  function automatic logic [31:0] modelTarget(input logic [31:0] cur_pc, input logic [31:0] ir,
                                              input logic jr, input logic jal, input logic beq,
                                              input logic flag, input logic [31:0] rs);
    longint off;
    if (jr) return rs & 32'hFFFF_FFFC;
    if (jal) return ((cur_pc + 32'd4) & 32'hF000_0000) | ({6'd0, ir[25:0]} << 2);
    if (beq && flag) begin
      off = longint'($signed(ir[15:0]));
      return 32'(longint'(cur_pc) + 4 + off * 4);
    end
    return cur_pc + 32'd4;
  endfunction

  // model: one architectural step per rising edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 32'h0; m_inst <= 32'h0; m_addr <= 32'h0;
      m_busy <= 1'b0; m_halted <= 1'b0; m_err <= 1'b0; m_waited <= 0;
    end else if (stop) begin
      m_pc <= 32'h0; m_inst <= 32'h0; m_addr <= 32'h0;
      m_busy <= 1'b0; m_halted <= 1'b0; m_err <= 1'b0; m_waited <= 0;
    end else if (m_halted) begin
      m_busy <= 1'b0;
    end else if (m_busy) begin
      if (imem_ready) begin
        m_inst <= imem_rdata; m_busy <= 1'b0; m_waited <= 0;
      end else if (m_waited + 1 == 255) begin
        m_err <= 1'b1; m_inst <= 32'h0; m_busy <= 1'b0; m_waited <= 0;
      end else begin
        m_waited <= m_waited + 1;
      end
    end else if (next && hlt) begin
      m_halted <= 1'b1;
    end else begin
      if (next) begin
        m_pc <= modelTarget(m_pc, m_inst, JR, JAL_or_J, BEQ_or_BNE, alu_flag, rs_data);
        if (JR && (rs_data[1:0] != 2'b00)) m_err <= 1'b1;
      end
      if (inst_re) begin
        m_busy <= 1'b1;
        m_addr <= next ? modelTarget(m_pc, m_inst, JR, JAL_or_J, BEQ_or_BNE, alu_flag, rs_data) : m_pc;
      end
    end
  end

  // compare DUT against model every falling edge while out of reset
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("pc", pc, m_pc);
      checkOutput("pc_plus4", pc_plus4, m_pc + 32'd4);
      checkOutput("inst", inst, m_inst);
      checkOutput("imem_req", {31'd0, imem_req}, {31'd0, m_busy});
      if (m_busy) checkOutput("imem_addr", imem_addr, m_addr);
      checkOutput("pause", {31'd0, pause}, {31'd0, m_busy && !imem_ready});
      checkOutput("halted", {31'd0, halted}, {31'd0, m_halted});
      checkOutput("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
      if (pause) pause_cnt++;
    end
  end

  // drive one cycle of controller inputs, then clear the pulses
  task automatic applyStimulus(input logic ire, input logic nxt, input logic jal, input logic beq,
                               input logic jr, input logic h, input logic flag, input logic [31:0] rs);
    inst_re = ire; next = nxt; JAL_or_J = jal; BEQ_or_BNE = beq;
    JR = jr; hlt = h; alu_flag = flag; rs_data = rs;
    @(posedge clk); #1;
    inst_re = 1'b0; next = 1'b0; JAL_or_J = 1'b0; BEQ_or_BNE = 1'b0;
    JR = 1'b0; hlt = 1'b0; alu_flag = 1'b0; rs_data = 32'h0;
  endtask

  // memory answers after 'delay' not-ready cycles
  task automatic completeFetch(input logic [31:0] data, input int delay);
    imem_rdata = data;
    repeat (delay) begin @(posedge clk); #1; end
    imem_ready = 1'b1;
    @(posedge clk); #1;
    imem_ready = 1'b0;
  endtask

  task automatic doStop();
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; stop = 1'b0; inst_re = 1'b0; next = 1'b0; JAL_or_J = 1'b0;
    BEQ_or_BNE = 1'b0; JR = 1'b0; hlt = 1'b0; alu_flag = 1'b0; rs_data = 32'h0;
    imem_rdata = 32'h0; imem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_pc", pc, 32'h0);
    checkOutput("reset_inst", inst, 32'h0);
    checkOutput("reset_req", {31'd0, imem_req}, 32'd0);
    checkOutput("reset_addr", imem_addr, 32'h0);
    checkOutput("reset_pause", {31'd0, pause}, 32'd0);
    checkOutput("reset_halted", {31'd0, halted}, 32'd0);
    checkOutput("reset_err", {31'd0, fetch_err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] same-cycle ready fetch");
    pause_cnt = 0;
    imem_ready = 1'b1; imem_rdata = 32'h2008_0005;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("t1_req", {31'd0, imem_req}, 32'd1);
    checkOutput("t1_addr", imem_addr, 32'h0);
    @(posedge clk); #1;
    imem_ready = 1'b0;
    checkOutput("t1_inst", inst, 32'h2008_0005);
    checkOutput("t1_pause_cnt", pause_cnt, 0);

    $display("[TB] ready delayed 3 cycles");
    pause_cnt = 0;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'h0);
    completeFetch(32'h1111_2222, 3);
    checkOutput("t2_pause_cnt", pause_cnt, 3);
    checkOutput("t2_inst", inst, 32'h1111_2222);

    $display("[TB] branch taken / not taken");
    applyStimulus(1, 1, 0, 0, 1, 0, 0, 32'h0000_0100);
    checkOutput("t3_addr", imem_addr, 32'h0000_0100);
    completeFetch(32'h1000_FFFF, 0);
    checkOutput("t3_pc0", pc, 32'h0000_0100);
    applyStimulus(0, 1, 0, 1, 0, 0, 1, 32'h0);
    checkOutput("t3_taken", pc, 32'h0000_0100);
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 32'h0);
    checkOutput("t3_not_taken", pc, 32'h0000_0104);
    checkOutput("t3_err", {31'd0, fetch_err}, 32'd0);

    $display("[TB] jump and misaligned JR");
    applyStimulus(1, 1, 0, 0, 1, 0, 0, 32'h1000_0010);
    completeFetch(32'h0800_0040, 1);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 32'h0);
    checkOutput("t4_jump", pc, 32'h1000_0100);
    applyStimulus(0, 1, 0, 0, 1, 0, 0, 32'h0000_0203);
    checkOutput("t4_jr_pc", pc, 32'h0000_0200);
    checkOutput("t4_jr_err", {31'd0, fetch_err}, 32'd1);
    doStop();
    checkOutput("t4_stop_err", {31'd0, fetch_err}, 32'd0);
    checkOutput("t4_stop_pc", pc, 32'h0);

    $display("[TB] sequential wrap");
    applyStimulus(0, 1, 0, 0, 1, 0, 0, 32'hFFFF_FFFC);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("wrap_pc", pc, 32'h0);
    checkOutput("wrap_err", {31'd0, fetch_err}, 32'd0);

    $display("[TB] memory timeout");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'h0);
    n = 0;
    while (imem_req && n < 400) begin
      if (n == 10) begin inst_re = 1'b1; next = 1'b1; end
      if (n == 11) begin inst_re = 1'b0; next = 1'b0; end
      @(posedge clk); #1;
      n++;
    end
    checkOutput("t5_wait_cycles", n, 255);
    checkOutput("t5_err", {31'd0, fetch_err}, 32'd1);
    checkOutput("t5_inst", inst, 32'h0);
    checkOutput("t5_req", {31'd0, imem_req}, 32'd0);
    doStop();

    $display("[TB] halt and stop");
    applyStimulus(0, 1, 0, 0, 1, 0, 0, 32'h0000_0040);
    applyStimulus(0, 1, 0, 0, 0, 1, 0, 32'h0);
    checkOutput("t6_halted", {31'd0, halted}, 32'd1);
    checkOutput("t6_pc_held", pc, 32'h0000_0040);
    for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("t6_req_halt", {31'd0, imem_req}, 32'd0);
    checkOutput("t6_pc_after", pc, 32'h0000_0040);
    doStop();
    checkOutput("t6_stop_pc", pc, 32'h0);
    checkOutput("t6_stop_halted", {31'd0, halted}, 32'd0);

    $display("[TB] async reset during wait");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t7_req_async", {31'd0, imem_req}, 32'd0);
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    checkOutput("t7_inst", inst, 32'h0);
    checkOutput("t7_req", {31'd0, imem_req}, 32'd0);
    checkOutput("t7_pc", pc, 32'h0);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
